// File: rtl/imem_loader.sv
// Boot loader: streams a byte-wide program image into fetch-stage IMem,
// holding the core while loading and pulsing core_rst when finished.
module imem_loader #(
  parameter int WORDS_MAX = 256,
  parameter int CNT_W     = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        load_active,
  output logic [31:0] if_newPC,
  output logic        if_we,
  output logic [31:0] if_wins,
  output logic        core_hold,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_BYTE,
    S_ADDR,
    S_WRITE,
    S_FINISH,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      wins_q, wins_d;
  logic             we_q, we_d;
  logic             crst_q, crst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             acc;
  logic [CNT_W-1:0] hdr;
  logic [CNT_W-1:0] word_nxt;

  assign in_ready = (state_q == S_HDR_HI) ||
                    (state_q == S_HDR_LO) ||
                    (state_q == S_BYTE);
  assign load_active = (state_q != S_IDLE);
  assign core_hold   = (state_q != S_IDLE);
  assign if_newPC    = pc_q;
  assign if_we       = we_q;
  assign if_wins     = wins_q;
  assign core_rst    = crst_q;
  assign done        = done_q;
  assign err         = err_q;

  assign acc      = in_valid && in_ready;
  assign hdr      = {cnt_q[CNT_W-1:8], in_data};
  assign word_nxt = word_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pc_d       = pc_q;
    wins_d     = wins_q;
    we_d       = 1'b0;
    crst_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR_HI;
          err_d      = 1'b0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
        end
      end
      S_HDR_HI: begin
        if (acc) begin
          cnt_d[CNT_W-1:8] = (CNT_W-8)'(in_data);
          state_d          = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (acc) begin
          cnt_d[7:0] = in_data;
          if (hdr == '0) begin
            state_d = S_FINISH;
            crst_d  = 1'b1;
            done_d  = 1'b1;
          end else if (hdr > CNT_W'(WORDS_MAX)) begin
            state_d = S_ERR;
            crst_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = S_BYTE;
            byte_cnt_d = '0;
          end
        end
      end
      S_BYTE: begin
        if (acc) begin
          // big-endian: first byte shifts up to [31:24]
          wins_d     = {wins_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_ADDR;
            pc_d    = 32'(word_cnt_q) << 2;
          end
        end
      end
      S_ADDR: begin
        state_d = S_WRITE;
        we_d    = 1'b1;
      end
      S_WRITE: begin
        word_cnt_d = word_nxt;
        byte_cnt_d = '0;
        if (word_nxt == cnt_q) begin
          state_d = S_FINISH;
          crst_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = S_BYTE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      pc_q       <= '0;
      wins_q     <= '0;
      we_q       <= 1'b0;
      crst_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pc_q       <= pc_d;
      wins_q     <= wins_d;
      we_q       <= we_d;
      crst_q     <= crst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of whole loads plus
// cycle-exact sequences for write timing, reset mid-load and busy start.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, load_active, if_we, core_hold;
  logic        core_rst, done, err;
  logic [31:0] if_newPC, if_wins;

  imem_loader #(.WORDS_MAX(256), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_active(load_active), .if_newPC(if_newPC), .if_we(if_we),
    .if_wins(if_wins), .core_hold(core_hold), .core_rst(core_rst),
    .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] imem [256];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int acc_bytes = 0;
  int done_cnt = 0;
  int rst_cnt = 0;

  always @(posedge CLK)
    if (if_we) imem[if_newPC[9:2]] <= if_wins;

  always @(negedge CLK) begin
    if (if_we) begin
      wr_addr.push_back(if_newPC);
      wr_data.push_back(if_wins);
    end
    if (in_valid && in_ready) acc_bytes++;
    if (done) done_cnt++;
    if (core_rst) rst_cnt++;
  end

  typedef struct {
    logic [15:0] hdr;
    int          gap;
    bit          poke;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
    int          exp_bytes;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] wgen(input int i);
    return 32'hA5C3_0F00 ^ (i * 32'h0103_0507);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
    if (g > 0) in_valid = 1'b0;
    repeat (g) step();
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100; t++) begin
      if (in_ready) begin
        step();
        return;
      end
      step();
    end
    n_chk++;
    n_fail++;
    $display("FAIL byte_timeout: in_ready=0 expected 1");
  endtask

  task automatic run_load(input vec_t v, input int idx);
    int b_acc, b_done, b_rst, b_wr, nw;
    logic [31:0] w;
    b_acc  = acc_bytes;
    b_done = done_cnt;
    b_rst  = rst_cnt;
    b_wr   = wr_addr.size();
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("v%0d_err_clr", idx), err, 0);
    chk($sformatf("v%0d_active", idx), load_active, 1);
    send_byte(v.hdr[15:8], v.gap);
    send_byte(v.hdr[7:0], v.gap);
    nw = v.exp_err ? 0 : int'(v.hdr);
    for (int i = 0; i < nw; i++) begin
      w = wgen(i);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31-8*k -: 8], v.gap);
        if (v.poke && i == 0 && k == 0) begin
          in_valid = 1'b0;
          start = 1'b1;
          step();
          start = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 20 && load_active; t++) step();
    chk($sformatf("v%0d_to_idle", idx), load_active, 0);
    chk($sformatf("v%0d_done", idx), done_cnt - b_done, v.exp_done);
    chk($sformatf("v%0d_crst", idx), rst_cnt - b_rst, 1);
    chk($sformatf("v%0d_err", idx), err, v.exp_err);
    chk($sformatf("v%0d_nwr", idx), wr_addr.size() - b_wr, v.exp_wr);
    chk($sformatf("v%0d_bytes", idx), acc_bytes - b_acc, v.exp_bytes);
    if (wr_addr.size() >= b_wr + v.exp_wr) begin
      for (int j = 0; j < v.exp_wr; j++) begin
        chk($sformatf("v%0d_addr%0d", idx, j), wr_addr[b_wr+j], j * 4);
        chk($sformatf("v%0d_data%0d", idx, j), wr_data[b_wr+j], wgen(j));
        chk($sformatf("v%0d_imem%0d", idx, j), imem[j], wgen(j));
      end
    end
    if (v.exp_err) begin
      repeat (3) step();
      chk($sformatf("v%0d_err_sticky", idx), err, 1);
      chk($sformatf("v%0d_no_done", idx), done, 0);
    end
  endtask

  logic [7:0] b0 [4];
  logic [7:0] b1 [4];
  int rc;
  vec_t fresh;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: sim time %0t limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'd2,     0, 1'b0, 1'b1, 1'b0, 2,   10};
    vecs[1] = '{16'd0,     0, 1'b0, 1'b1, 1'b0, 0,   2};
    vecs[2] = '{16'd257,   0, 1'b0, 1'b0, 1'b1, 0,   2};
    vecs[3] = '{16'd3,     3, 1'b0, 1'b1, 1'b0, 3,   14};
    vecs[4] = '{16'd2,     0, 1'b1, 1'b1, 1'b0, 2,   10};
    vecs[5] = '{16'hFFFF,  0, 1'b0, 1'b0, 1'b1, 0,   2};
    vecs[6] = '{16'd1,     2, 1'b0, 1'b1, 1'b0, 1,   6};
    vecs[7] = '{16'd256,   0, 1'b0, 1'b1, 1'b0, 256, 1026};
    b0 = '{8'h20, 8'h08, 8'h00, 8'h05};
    b1 = '{8'hAC, 8'h09, 8'h00, 8'h00};

    repeat (2) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_active", load_active, 0);
    chk("rst_pc", if_newPC, 0);
    chk("rst_we", if_we, 0);
    chk("rst_wins", if_wins, 0);
    chk("rst_hold", core_hold, 0);
    chk("rst_crst", core_rst, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    RST = 1'b1;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    chk("hdr_ready", in_ready, 1);
    chk("hdr_hold", core_hold, 1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int k = 0; k < 4; k++) send_byte(b0[k], 0);
    chk("w0_addr_pc", if_newPC, 0);
    chk("w0_addr_we", if_we, 0);
    chk("w0_addr_rdy", in_ready, 0);
    chk("w0_addr_crst", core_rst, 0);
    step();
    chk("w0_we", if_we, 1);
    chk("w0_pc", if_newPC, 0);
    chk("w0_ins", if_wins, 32'h2008_0005);
    chk("w0_wr_rdy", in_ready, 0);
    chk("w0_wr_crst", core_rst, 0);
    step();
    in_valid = 1'b0;
    chk("w1_byte_rdy", in_ready, 1);
    chk("w1_byte_we", if_we, 0);
    for (int k = 0; k < 4; k++) send_byte(b1[k], 0);
    in_valid = 1'b0;
    chk("w1_addr_pc", if_newPC, 4);
    chk("w1_addr_we", if_we, 0);
    step();
    chk("w1_we", if_we, 1);
    chk("w1_pc", if_newPC, 4);
    chk("w1_ins", if_wins, 32'hAC09_0000);
    step();
    chk("fin_crst", core_rst, 1);
    chk("fin_done", done, 1);
    chk("fin_we", if_we, 0);
    chk("fin_active", load_active, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("idle_crst", core_rst, 0);
    chk("idle_done", done, 0);
    chk("idle_active", load_active, 0);
    chk("idle_hold", core_hold, 0);
    step();
    chk("fin_start_ignored", load_active, 0);
    chk("imem0", imem[0], 32'h2008_0005);
    chk("imem1", imem[1], 32'hAC09_0000);

    for (int i = 0; i < 8; i++) run_load(vecs[i], i);

    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    in_valid = 1'b0;
    step();
    step();
    chk("mid_imem0", imem[0], 32'h1122_3344);
    send_byte(8'h55, 0);
    in_valid = 1'b0;
    rc = rst_cnt;
    RST = 1'b0;
    step();
    chk("mid_active", load_active, 0);
    chk("mid_rdy", in_ready, 0);
    chk("mid_wins", if_wins, 0);
    chk("mid_pc", if_newPC, 0);
    chk("mid_we", if_we, 0);
    chk("mid_crst", core_rst, 0);
    RST = 1'b1;
    step();
    chk("mid_no_crst", rst_cnt - rc, 0);
    chk("mid_imem_kept", imem[0], 32'h1122_3344);
    fresh = '{16'd2, 1, 1'b0, 1'b1, 1'b0, 2, 10};
    run_load(fresh, 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time controller that streams a program image into the instruction-fetch stage's instruction memory over a byte-wide valid/ready link.
- While loading, it owns the fetch stage's newPC, WE and W_Ins inputs and holds the rest of the pipeline with core_hold.
- On completion it pulses core_rst so fetch restarts at PC 0.

Parameters:
- WORDS_MAX, 256, maximum image size in 32-bit words; equals instruction memory depth.
- CNT_W, 16, width of the header word count and the internal word counter.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-low (RST=0 resets on the rising CLK edge)
- start  in  1  single-cycle request to begin a load; honoured only in IDLE
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts a byte this cycle
- load_active  out  1  loader owns the fetch-stage write/PC inputs; selects if_newPC in the PC mux
- if_newPC  out  32  address presented to fetch newPC
- if_we  out  1  fetch-stage instruction write enable
- if_wins  out  32  instruction word to write
- core_hold  out  1  freeze all non-fetch pipeline stages
- core_rst  out  1  active-high reset pulse to the fetch stage and core
- done  out  1  one-cycle pulse when a load completes successfully
- err  out  1  sticky error flag; cleared by the next accepted start or by reset

Behaviour:
- Reset (RST=0): state IDLE. in_ready, load_active, if_we, core_hold, core_rst, done and err are 0. if_newPC, if_wins, the word counter, the byte counter and the stored count are 0.
- A byte is accepted only on a cycle where in_valid=1 and in_ready=1. in_ready is 1 only in HDR_HI, HDR_LO and BYTE. in_ready is a registered state decode and does not depend on in_valid.
- IDLE: start=1 → HDR_HI next cycle; clear err, word_cnt and byte_cnt. start is ignored in every other state.
- HDR_HI: on an accepted byte, cnt[15:8] = byte → HDR_LO.
- HDR_LO: on an accepted byte, cnt[7:0] = byte, then branch on the full 16-bit count:
  - count = 0 → FINISH.
  - count > WORDS_MAX → ERR.
  - otherwise → BYTE.
- BYTE: collect 4 bytes big-endian; the first byte goes to if_wins[31:24]. byte_cnt runs 0..3. When the 4th byte is accepted → ADDR.
- ADDR (1 cycle): if_newPC = word_cnt<<2, if_we = 0. The fetch PC register captures the address at this edge.
- WRITE (1 cycle): if_we = 1, with if_newPC and if_wins held. word_cnt increments at the end of the cycle. Then:
  - → FINISH if the incremented word_cnt equals the stored count;
  - otherwise → BYTE with byte_cnt = 0.
- Per-word cost is 4 accepted bytes plus 2 cycles. No byte is accepted during ADDR or WRITE.
- FINISH (1 cycle): core_rst = 1, done = 1, if_we = 0 → IDLE.
- ERR (1 cycle): err set (sticky), core_rst = 1, no done pulse → IDLE. Instruction memory is left untouched.
- load_active and core_hold are 1 in every state except IDLE.
- core_rst is 1 only in FINISH and ERR.
- core_rst is 0 during ADDR/WRITE; the fetch stage writes only while its reset is low.
- All outputs are registered, except in_ready, load_active and core_hold, which are decoded from the state register.
- Counter widths:
  - word_cnt is CNT_W bits, and if_newPC is its zero-extended value shifted left by 2.
  - With count ≤ WORDS_MAX, word_cnt never exceeds WORDS_MAX and the address never wraps.
- in_valid with in_ready=0: the byte is not consumed. The source must hold it; nothing is dropped.
- in_valid stalls mid-word: the FSM waits in BYTE indefinitely; partial bytes are retained and there is no timeout.
- Reset mid-load: immediate return to IDLE with all outputs at reset values. Words already written remain in memory; no core_rst pulse is generated.
- start asserted in FINISH/ERR is ignored. It takes effect only when sampled in IDLE.

Test Plan:
- Load 2 words: start, then bytes 00 02 | 20 08 00 05 | AC 09 00 00 → if_we pulses with (if_newPC, if_wins) = (0x0, 0x20080005) then (0x4, 0xAC090000); done and core_rst high one cycle; fetch then reads IMem[0]=0x20080005.
- Zero-length image: start, bytes 00 00 → FINISH after HDR_LO; no if_we pulse; done=1 for one cycle.
- Oversize: header 01 01 (257 > 256) → err=1 and remains 1; no if_we; done stays 0; next start clears err.
- Backpressure/gaps: randomised in_valid gaps and in_valid held during ADDR/WRITE → exactly 4N+2 bytes consumed; words written in order at addresses 0,4,8,…
- Reset mid-load: RST=0 after word 1 is written → next cycle state IDLE, all outputs 0, no core_rst; a fresh start reloads correctly.
- Start while busy: second start during BYTE → ignored; the load completes with the original count.
